conv_add_tree_pipe: RTL
=======================

# conv_add_tree_pipe

Parametrised, fully pipelined adder tree with channel accumulation, bias add and output saturation. It sits between the convolution multiplier array and the activation/pooling stage. It replaces the fixed 25-lane product buffer with one that:
- registers the N lane products,
- reduces them through registered adder levels,
- accumulates CH_NUM successive tree results (one per input channel) plus a bias,
- emits one saturated sum per output pixel.

It accepts one beat per cycle and has no backpressure.

## Interface
Parameters:
- NUM_IN, 25, number of product lanes (≥2)
- IN_W, 32, signed width of each product lane
- OUT_W, 32, signed width of sum_o (≤ SUM_W)
- CH_NUM, 1, tree results accumulated per output (≥1)
- Derived (localparam): LEVELS = clog2(NUM_IN); SUM_W = IN_W + LEVELS + clog2(CH_NUM) + 1

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- prod_i  in  NUM_IN*IN_W  packed signed products; lane k = bits [k*IN_W +: IN_W]
- prod_valid_i  in  1  prod_i valid this cycle
- bias_i  in  OUT_W  signed bias; held stable by controller for a whole group
- clear_i  in  1  synchronous flush of pipeline and accumulator
- sum_o  out  OUT_W  signed saturated result
- sum_valid_o  out  1  one-cycle pulse, sum_o valid
- ovf_o  out  1  saturation occurred on the sum_o beat; qualified by sum_valid_o

## Operation
- **Clock and reset:** one clock; reset is asynchronous and active-low.
- **Reset values:** sum_o=0, sum_valid_o=0, ovf_o=0. All lane/tree/accumulator registers, valid bits and the channel counter ch_cnt are 0.
- **Stage 0 (input register):** loads prod_i when prod_valid_i=1; holds otherwise. v[0] <= prod_valid_i & ~clear_i.
- **Stages 1..LEVELS (tree levels):** each level adds adjacent pairs, sign-extended to the level width.
  - An odd leftover element passes through registered.
  - Lanes beyond NUM_IN are constant 0.
  - Level data registers load only when the previous stage's valid bit is 1.
  - v[l] <= v[l-1] & ~clear_i.
- **Accumulate stage,** on tree-valid (v[LEVELS]=1):
  - ch_cnt==0: acc = sext(bias_i) + tree.
  - Else: acc = acc + tree.
  - All arithmetic is SUM_W signed, so there is no internal overflow.
  - If ch_cnt==CH_NUM-1: ch_cnt <= 0, sum_o <= sat(acc_next), ovf_o <= saturation flag, sum_valid_o <= 1.
  - Otherwise: ch_cnt <= ch_cnt+1, sum_valid_o <= 0.
- **Saturation:**
  - acc_next > 2^(OUT_W-1)-1 → max value.
  - acc_next < -2^(OUT_W-1) → min value.
  - Otherwise truncation to OUT_W is exact.
- **When CH_NUM=1:** every tree result produces an output. bias_i is still added.
- **Idle cycles:** allowed anywhere within a group. ch_cnt and acc hold while v[LEVELS]=0.
- **Outputs between pulses:** sum_o and ovf_o hold their last values while sum_valid_o=0.
- **clear_i=1:**
  - Next cycle: all v[*]=0, ch_cnt=0, acc=0, sum_valid_o=0.
  - Data registers other than acc are not cleared.
  - Simultaneous prod_valid_i is dropped.
  - A group completing in the same cycle as clear_i does not output.
- **Async reset mid-operation:** all outputs go to reset values immediately. In-flight beats are discarded. No sum_valid_o after release until new input.

## Timing
- Latency from a prod_valid_i beat at cycle t to its tree result: v[LEVELS] high at t+1+LEVELS.
- Latency to the output: sum_valid_o high at t+2+LEVELS when that beat closes a group. NUM_IN=25 gives LEVELS=5, so the output comes 7 cycles after the last beat of the group.
- Throughput is one beat per cycle. Back-to-back groups produce back-to-back sum_valid_o pulses, one per CH_NUM beats.
- sum_valid_o is exactly one cycle wide per group.
- bias_i is sampled at the accumulate stage on the group's first tree-valid beat (ch_cnt==0).

## Test plan
- **Single beat:** NUM_IN=25, CH_NUM=1, all lanes=1, bias=0, one prod_valid_i beat at t → sum_o=25, ovf_o=0, sum_valid_o high only at t+7.
- **Back-to-back beats:** three consecutive beats with all lanes = 1, 2, -3; bias=4 → sum_valid_o high on three consecutive cycles with sum_o=29, 54, -71.
- **Channel accumulation:** CH_NUM=6, bias=10, six beats with lane0 = 1..6 and other lanes 0, idle cycles inserted between beats 2 and 3 → exactly one pulse, sum_o=31, 7 cycles after beat 6.
- **Saturation:** OUT_W=16, all 25 lanes=2000 → sum_o=32767, ovf_o=1. All lanes=-2000 → sum_o=-32768, ovf_o=1.
- **Clear mid-group:** CH_NUM=6, three beats of lane0=100, then clear_i, then six beats of lane0=1, bias=0 → exactly one pulse, sum_o=6. A prod_valid_i beat coincident with clear_i does not contribute.
- **Async reset mid-operation:** beats in flight, rst_n pulsed low asynchronously → sum_o=0, sum_valid_o=0 immediately; no pulse after release. A subsequent single beat with all lanes=1 gives sum_o=25 with normal latency.

Source files
------------

// File: rtl/conv_add_tree_pipe.sv
// conv_add_tree_pipe: registered product lanes, pipelined adder tree,
// per-pixel channel accumulation with bias and saturating output.
module conv_add_tree_pipe #(
  parameter int NUM_IN = 25,
  parameter int IN_W   = 32,
  parameter int OUT_W  = 32,
  parameter int CH_NUM = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*IN_W-1:0]  prod_i,
  input  logic                    prod_valid_i,
  input  logic [OUT_W-1:0]        bias_i,
  input  logic                    clear_i,
  output logic [OUT_W-1:0]        sum_o,
  output logic                    sum_valid_o,
  output logic                    ovf_o
);

  localparam int LEVELS = $clog2(NUM_IN);
  localparam int CHB    = $clog2(CH_NUM);
  localparam int SUM_W  = IN_W + LEVELS + CHB + 1;
  localparam int CW     = (CHB > 0) ? CHB : 1;

  localparam logic [CW-1:0] LAST = CW'(CH_NUM - 1);

  localparam logic signed [SUM_W-1:0] MAXV =
    $signed({SUM_W{1'b1}} >> (SUM_W - OUT_W + 1));
  localparam logic signed [SUM_W-1:0] MINV = ~MAXV;

  logic [IN_W-1:0]   lane_q [NUM_IN];
  logic [SUM_W-1:0]  lane_x [NUM_IN];
  logic [LEVELS:0]   v_q;

  // Input register: capture all lanes on a valid beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_IN; k++) lane_q[k] <= '0;
    end else if (prod_valid_i) begin
      for (int k = 0; k < NUM_IN; k++)
        lane_q[k] <= prod_i[k*IN_W +: IN_W];
    end
  end

  // Sign-extend lanes to the accumulator width
  always_comb begin
    for (int k = 0; k < NUM_IN; k++)
      lane_x[k] = SUM_W'($signed(lane_q[k]));
  end

  // Valid shift chain; clear drops every in-flight beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      v_q <= {v_q[LEVELS-1:0], prod_valid_i}
           & {(LEVELS+1){~clear_i}};
    end
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int PN = (NUM_IN + (1 << (l-1)) - 1) >> (l-1);
    localparam int CN = (NUM_IN + (1 << l) - 1) >> l;

    logic [SUM_W-1:0] q [CN];
    logic [SUM_W-1:0] d [CN];

    for (genvar i = 0; i < CN; i++) begin : g_node
      logic [SUM_W-1:0] a;
      logic [SUM_W-1:0] b;
      if (l == 1) begin : g_src0
        assign a = lane_x[2*i];
        if (2*i + 1 < PN) begin : g_pair
          assign b = lane_x[2*i+1];
        end else begin : g_odd
          assign b = '0;
        end
      end else begin : g_srcn
        assign a = g_lvl[l-1].q[2*i];
        if (2*i + 1 < PN) begin : g_pair
          assign b = g_lvl[l-1].q[2*i+1];
        end else begin : g_odd
          assign b = '0;
        end
      end
      assign d[i] = a + b;
    end

    // Tree level register: load pair sums when previous stage is valid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < CN; k++) q[k] <= '0;
      end else if (v_q[l-1]) begin
        for (int k = 0; k < CN; k++) q[k] <= d[k];
      end
    end
  end

  logic [SUM_W-1:0]        tree;
  logic signed [SUM_W-1:0] bias_x;
  logic signed [SUM_W-1:0] base;
  logic signed [SUM_W-1:0] acc_d;
  logic signed [SUM_W-1:0] acc_q;
  logic [CW-1:0]           ch_cnt_q;
  logic                    sat_hi;
  logic                    sat_lo;
  logic                    last;
  logic [OUT_W-1:0]        sat_val;
  logic [OUT_W-1:0]        sum_q;
  logic                    sum_valid_q;
  logic                    ovf_q;

  assign tree = g_lvl[LEVELS].q[0];

  // Next accumulator value and its saturated OUT_W form
  always_comb begin
    bias_x  = SUM_W'($signed(bias_i));
    base    = (ch_cnt_q == '0) ? bias_x : acc_q;
    acc_d   = base + $signed(tree);
    sat_hi  = acc_d > MAXV;
    sat_lo  = acc_d < MINV;
    last    = ch_cnt_q == LAST;
    sat_val = acc_d[OUT_W-1:0];
    if (sat_hi) sat_val = MAXV[OUT_W-1:0];
    if (sat_lo) sat_val = MINV[OUT_W-1:0];
  end

  // Accumulate one tree result per channel; emit on group close
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      ch_cnt_q    <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (clear_i) begin
      acc_q       <= '0;
      ch_cnt_q    <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_valid_q <= 1'b0;
      if (v_q[LEVELS]) begin
        acc_q <= acc_d;
        if (last) begin
          ch_cnt_q    <= '0;
          sum_q       <= sat_val;
          ovf_q       <= sat_hi | sat_lo;
          sum_valid_q <= 1'b1;
        end else begin
          ch_cnt_q <= ch_cnt_q + CW'(1);
        end
      end
    end
  end

  assign sum_o       = sum_q;
  assign sum_valid_o = sum_valid_q;
  assign ovf_o       = ovf_q;

endmodule
